// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Instruction Fetch stage of a 5-stage MIPS pipeline. Holds the
//               PC, computes PC+4, reads the instruction from an internal
//               debug-loaded instruction memory, redirects the PC for
//               branch / jump / jump-register targets and freezes fetch on
//               the HALT instruction.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   i_clock            system clock, rising edge
//   i_reset            asynchronous, active-high reset
//   i_enable           global run/step enable from the debug unit
//   i_stall            hazard-unit stall, holds the PC
//   i_pc_src           next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jr
//   i_branch_addr      branch target
//   i_jump_addr        jump target
//   i_jr_addr          jump-register target
//   i_wr_en            instruction memory write strobe (debug load)
//   i_wr_addr          word address to write
//   i_wr_data          word to write
//   o_IF_adder_result  PC+4 (combinational)
//   o_IF_instruction   instruction at PC (combinational)
//   o_pc               current PC
//   o_halt             HALT reached, fetch frozen (registered)
//   o_fetch_count      number of PC loads (only with IF_FETCH_COUNT_EN)
// Optional macro: IF_FETCH_COUNT_EN adds the o_fetch_count output.
// ============================================================================
module instruction_fetch #(
    parameter int                          NB_PC          = 32,
    parameter int                          NB_INSTRUCTION = 32,
    parameter int                          NB_MEM_ADDR    = 8,
    parameter logic [NB_INSTRUCTION-1:0]   HALT_OPCODE    = 32'hFFFF_FFFF
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic                        i_stall,
    input  logic [1:0]                  i_pc_src,
    input  logic [NB_PC-1:0]            i_branch_addr,
    input  logic [NB_PC-1:0]            i_jump_addr,
    input  logic [NB_PC-1:0]            i_jr_addr,
    input  logic                        i_wr_en,
    input  logic [NB_MEM_ADDR-1:0]      i_wr_addr,
    input  logic [NB_INSTRUCTION-1:0]   i_wr_data,
    output logic [NB_PC-1:0]            o_IF_adder_result,
    output logic [NB_INSTRUCTION-1:0]   o_IF_instruction,
    output logic [NB_PC-1:0]            o_pc,
    output logic                        o_halt
`ifdef IF_FETCH_COUNT_EN
    ,
    output logic [31:0]                 o_fetch_count
`endif
);

    localparam int          c_MEM_DEPTH  = 2 ** NB_MEM_ADDR;
    localparam logic [1:0]  c_SRC_SEQ    = 2'b00;
    localparam logic [1:0]  c_SRC_BRANCH = 2'b01;
    localparam logic [1:0]  c_SRC_JUMP   = 2'b10;

    typedef enum logic [0:0] {
        RUNNING = 1'b0,
        HALTED  = 1'b1
    } state_t;

    state_t                         r_state;
    logic [NB_PC-1:0]               r_pc;
    logic                           r_halt;
    logic [NB_INSTRUCTION-1:0]      r_mem [0:c_MEM_DEPTH-1];

    logic [NB_MEM_ADDR-1:0]         w_mem_index;
    logic [NB_INSTRUCTION-1:0]      w_instruction;
    logic [NB_PC-1:0]               w_pc_plus4;
    logic [NB_PC-1:0]               w_target;
    logic [NB_PC-1:0]               w_pc_next;
    logic                           w_advance;
    logic                           w_halt_detect;
    logic                           w_load;

    // Word-addressed read; PC bits above the memory depth are ignored so the
    // address space wraps onto the array.
    assign w_mem_index   = r_pc[NB_MEM_ADDR+1:2];
    assign w_instruction = r_mem[w_mem_index];
    assign w_pc_plus4    = r_pc + NB_PC'(4);

    always_comb begin
        w_target = w_pc_plus4;
        case (i_pc_src)
            c_SRC_SEQ:    w_target = w_pc_plus4;
            c_SRC_BRANCH: w_target = i_branch_addr;
            c_SRC_JUMP:   w_target = i_jump_addr;
            default:      w_target = i_jr_addr;
        endcase
    end

    // Targets are word-aligned by clearing the two low bits.
    assign w_pc_next = w_target & ~NB_PC'(3);

    assign w_advance     = (r_state == RUNNING) && i_enable && !i_stall;
    // A redirect in the same cycle as the HALT word takes precedence.
    assign w_halt_detect = w_advance && (i_pc_src == c_SRC_SEQ) &&
                           (w_instruction == HALT_OPCODE);
    assign w_load        = w_advance && !w_halt_detect;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= RUNNING;
            r_pc    <= '0;
            r_halt  <= 1'b0;
        end else begin
            case (r_state)
                RUNNING: begin
                    if (w_halt_detect) begin
                        r_state <= HALTED;
                        r_halt  <= 1'b1;
                    end else if (w_load) begin
                        r_pc    <= w_pc_next;
                    end
                end
                HALTED: begin
                    r_halt  <= 1'b1;
                end
                default: begin
                    r_state <= RUNNING;
                    r_halt  <= 1'b0;
                end
            endcase
        end
    end

    // Memory is deliberately outside the reset domain: debug loads issued
    // while reset is asserted must still land.
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

`ifdef IF_FETCH_COUNT_EN
    logic [31:0] r_fetch_count;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_fetch_count <= '0;
        end else if (w_load) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign o_fetch_count = r_fetch_count;
`endif

    assign o_IF_adder_result = w_pc_plus4;
    assign o_IF_instruction  = w_instruction;
    assign o_pc              = r_pc;
    assign o_halt            = r_halt;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Scoreboard bench for instruction_fetch. The driver pushes the
//               hand-computed expected outputs for each cycle; a monitor pops
//               and compares them on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        stall;
    logic [1:0]  pc_src;
    logic [31:0] br_addr;
    logic [31:0] jp_addr;
    logic [31:0] jr_addr;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] adder;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        halt;
`ifdef IF_FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    instruction_fetch dut (
        .i_clock           (clk),
        .i_reset           (reset),
        .i_enable          (enable),
        .i_stall           (stall),
        .i_pc_src          (pc_src),
        .i_branch_addr     (br_addr),
        .i_jump_addr       (jp_addr),
        .i_jr_addr         (jr_addr),
        .i_wr_en           (wr_en),
        .i_wr_addr         (wr_addr),
        .i_wr_data         (wr_data),
        .o_IF_adder_result (adder),
        .o_IF_instruction  (instr),
        .o_pc              (pc),
        .o_halt            (halt)
`ifdef IF_FETCH_COUNT_EN
        ,
        .o_fetch_count     (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] adder;
        logic [31:0] instr;
        logic        halt;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          vec    = 0;
    logic [31:0] cnt    = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp, input int id);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vector %0d): got 0x%08h, expected 0x%08h", name, id, act, exp);
        end
    endtask

    // Monitor: one expectation is consumed per falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vec++;
            cmp("pc",    pc,    e.pc,    vec);
            cmp("adder", adder, e.adder, vec);
            cmp("instr", instr, e.instr, vec);
            cmp("halt",  {31'd0, halt}, {31'd0, e.halt}, vec);
`ifdef IF_FETCH_COUNT_EN
            cmp("fetch_count", fetch_count, e.cnt, vec);
`endif
        end
    end

    task automatic expect_state(input logic [31:0] p, input logic [31:0] ins, input logic h);
        exp_t e;
        e.pc    = p;
        e.adder = p + 32'd4;
        e.instr = ins;
        e.halt  = h;
        e.cnt   = cnt;
        sb.push_back(e);
    endtask

    // Advance one rising edge; ld marks an edge on which the PC is loaded.
    task automatic tick(input bit ld);
        @(posedge clk);
        #1;
        if (ld) cnt = cnt + 32'd1;
    endtask

    task automatic mem_write(input logic [7:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick(0);
        wr_en   = 1'b0;
    endtask

    localparam logic [31:0] W0   = 32'h2001_0005;
    localparam logic [31:0] W1   = 32'h2002_0007;
    localparam logic [31:0] W2   = 32'h0000_0000;
    localparam logic [31:0] WH   = 32'hFFFF_FFFF;
    localparam logic [31:0] W4   = 32'h1111_0004;
    localparam logic [31:0] W5   = 32'h5555_5555;
    localparam logic [31:0] W16  = 32'h4040_4040;
    localparam logic [31:0] W32  = 32'h8080_8080;
    localparam logic [31:0] W255 = 32'hABCD_0255;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; stall = 1'b0; pc_src = 2'b00;
        br_addr = '0; jp_addr = '0; jr_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        tick(0);

        // Debug load while reset is held
        mem_write(8'd0,   W0);
        mem_write(8'd1,   W1);
        mem_write(8'd2,   W2);
        mem_write(8'd3,   WH);
        mem_write(8'd4,   W4);
        mem_write(8'd5,   W5);
        mem_write(8'd16,  W16);
        mem_write(8'd32,  W32);
        mem_write(8'd255, W255);
        expect_state(32'h0, W0, 1'b0);

        // Sequential run into HALT
        reset = 1'b0; enable = 1'b1; pc_src = 2'b00;
        tick(1); expect_state(32'h4, W1, 1'b0);
        tick(1); expect_state(32'h8, W2, 1'b0);
        tick(1); expect_state(32'hC, WH, 1'b0);
        tick(0); expect_state(32'hC, WH, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(0); expect_state(32'hC, WH, 1'b1);
        end

        // Asynchronous reset while halted
        tick(0);
        reset = 1'b1; #1; cnt = 0;
        expect_state(32'h0, W0, 1'b0);
        tick(0); reset = 1'b0;
        expect_state(32'h0, W0, 1'b0);

        // Stall hold at PC=4
        tick(1); expect_state(32'h4, W1, 1'b0);
        stall = 1'b1;
        tick(0); expect_state(32'h4, W1, 1'b0);
        tick(0); expect_state(32'h4, W1, 1'b0);
        tick(0); expect_state(32'h4, W1, 1'b0);
        stall = 1'b0;
        tick(1); expect_state(32'h8, W2, 1'b0);

        // Enable hold at PC=8
        enable = 1'b0;
        tick(0); expect_state(32'h8, W2, 1'b0);
        tick(0); expect_state(32'h8, W2, 1'b0);
        tick(0); expect_state(32'h8, W2, 1'b0);
        enable = 1'b1;
        tick(1); expect_state(32'hC, WH, 1'b0);

        // HALT word under stall: no transition
        stall = 1'b1;
        tick(0); expect_state(32'hC, WH, 1'b0);
        // HALT word with a branch redirect: branch wins
        stall = 1'b0; pc_src = 2'b01; br_addr = 32'h0;
        tick(1); expect_state(32'h0, W0, 1'b0);
        pc_src = 2'b00;

        // Branch / jump / jr redirects with alignment
        tick(1); expect_state(32'h4, W1, 1'b0);
        tick(1); expect_state(32'h8, W2, 1'b0);
        pc_src = 2'b01; br_addr = 32'h0000_0041;
        tick(1); expect_state(32'h40, W16, 1'b0);
        pc_src = 2'b10; jp_addr = 32'h0000_0080;
        tick(1); expect_state(32'h80, W32, 1'b0);
        pc_src = 2'b11; jr_addr = 32'h0000_0010;
        tick(1); expect_state(32'h10, W4, 1'b0);
        jr_addr = 32'h0000_0017;
        tick(1); expect_state(32'h14, W5, 1'b0);

        // Write the currently addressed word
        enable = 1'b0; wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'hDEAD_BEEF;
        tick(0); expect_state(32'h14, 32'hDEAD_BEEF, 1'b0);
        wr_en = 1'b0;

        // Address wrap and PC+4 wrap
        enable = 1'b1; pc_src = 2'b10; jp_addr = 32'h0000_0400;
        tick(1); expect_state(32'h400, W0, 1'b0);
        jp_addr = 32'hFFFF_FFFE;
        tick(1); expect_state(32'hFFFF_FFFC, W255, 1'b0);
        pc_src = 2'b00;
        tick(1); expect_state(32'h0, W0, 1'b0);

        // Run to HALT again, then reset; memory keeps its contents
        tick(1); expect_state(32'h4, W1, 1'b0);
        tick(1); expect_state(32'h8, W2, 1'b0);
        tick(1); expect_state(32'hC, WH, 1'b0);
        tick(0); expect_state(32'hC, WH, 1'b1);
        tick(0); expect_state(32'hC, WH, 1'b1);
        tick(0);
        reset = 1'b1; #1; cnt = 0;
        expect_state(32'h0, W0, 1'b0);
        tick(0); reset = 1'b0; enable = 1'b0;
        expect_state(32'h0, W0, 1'b0);
        jp_addr = 32'h0000_0014; pc_src = 2'b10; enable = 1'b1;
        tick(1); expect_state(32'h14, 32'hDEAD_BEEF, 1'b0);
        enable = 1'b0;

        // Drain the scoreboard (bounded)
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #2;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Instruction Fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of the IF/ID pipeline register.
- Holds the PC and computes PC+4.
- Reads the instruction from an internal instruction memory; the debug unit loads that memory before execution.
- Redirects the PC for branch, jump and jump-register targets, and detects the HALT instruction.

Parameters:
NB_PC, 32, PC and address-bus width
NB_INSTRUCTION, 32, instruction word width
NB_MEM_ADDR, 8, instruction memory word-address width (depth 2^NB_MEM_ADDR words)
HALT_OPCODE, 32'hFFFF_FFFF, encoding that stops fetch

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_enable  in  1  global run/step enable from debug unit
i_stall  in  1  hazard-unit stall; holds PC
i_pc_src  in  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jump-register
i_branch_addr  in  NB_PC  branch target from ID
i_jump_addr  in  NB_PC  jump target from ID
i_jr_addr  in  NB_PC  register target from ID
i_wr_en  in  1  instruction memory write strobe (debug load)
i_wr_addr  in  NB_MEM_ADDR  word address to write
i_wr_data  in  NB_INSTRUCTION  word to write
o_IF_adder_result  out  NB_PC  PC+4, consumed by IF/ID
o_IF_instruction  out  NB_INSTRUCTION  instruction at PC, consumed by IF/ID
o_pc  out  NB_PC  current PC
o_halt  out  1  HALT reached; fetch frozen

Behaviour:
- State machine: RUNNING, HALTED.
  - Reset forces RUNNING, PC=0, o_halt=0.
  - Memory contents are not affected by reset.
- Instruction read is combinational:
  - o_IF_instruction = mem[PC[NB_MEM_ADDR+1:2]].
  - Upper PC bits are ignored, so addresses beyond the depth wrap.
- o_IF_adder_result = PC+4, combinational, modulo 2^NB_PC (0xFFFF_FFFC+4 -> 0).
- PC update at the rising edge, in priority order:
  1. reset
  2. HALTED -> hold
  3. i_enable=0 -> hold
  4. i_stall=1 -> hold
  5. otherwise load the i_pc_src selection
- Loaded targets have bits [1:0] forced to 0, so misaligned targets are aligned.
- HALT detection:
  - In RUNNING with i_enable=1, i_stall=0, i_pc_src=00 and o_IF_instruction==HALT_OPCODE, the next state is HALTED and the PC does not advance (it stays on the HALT address).
  - If the same cycle has i_pc_src!=00, the redirect wins and HALTED is not entered.
  - If the same cycle has i_stall=1, there is no transition; detection re-evaluates next cycle.
- HALTED is left only by reset. o_halt=1 exactly while in HALTED, registered, asserted the cycle after detection.
- Memory write:
  - On a rising edge with i_wr_en=1, mem[i_wr_addr] <= i_wr_data.
  - Independent of state, enable and stall; PC is unaffected.
  - Writing the word currently addressed: o_IF_instruction shows the old word before the edge and the new word after it.
- Reset asserted mid-operation asynchronously clears PC, the state and (if present) the counter. A write strobed in the same cycle as reset is still performed.
- An undefined i_pc_src value (X) in simulation is not required to be handled.
- Outputs have no extra latency: instruction and PC+4 are valid in the same cycle as o_pc, and IF/ID registers them.

Optional Feature:
Macro IF_FETCH_COUNT_EN.
- Defined:
  - Adds output o_fetch_count (32 bits), reset to 0.
  - Increments by 1 on every edge where the PC is loaded (RUNNING, i_enable=1, i_stall=0, not entering HALTED).
  - Wraps 0xFFFF_FFFF -> 0 and holds while HALTED.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Load mem[0..3]={0x2001_0005,0x2002_0007,0x0000_0000,0xFFFF_FFFF} with i_enable=0, then release reset and set i_enable=1, i_pc_src=00 -> o_pc sequence 0,4,8,12; o_IF_adder_result 4,8,12,16; o_halt=1 one cycle after o_pc=12; o_pc stays 12 for 10 more cycles.
- PC=8, i_pc_src=01, i_branch_addr=0x0000_0041 -> next o_pc=0x40. Then i_pc_src=10, i_jump_addr=0x80 -> 0x80. Then i_pc_src=11, i_jr_addr=0x10 -> 0x10.
- Hold i_stall=1 for 3 cycles at PC=4 -> o_pc and o_IF_instruction unchanged; the PC resumes at 8 the cycle after release. Repeat with i_enable=0 -> same hold.
- HALT word at PC=12 with i_pc_src=01 and i_branch_addr=0 in the same cycle -> o_pc=0, o_halt stays 0. Assert i_reset for 1 cycle while HALTED -> o_pc=0, o_halt=0 immediately (asynchronous); memory is unchanged.
- Write mem[5]=0xDEAD_BEEF while PC=20 -> o_IF_instruction changes to 0xDEAD_BEEF right after the edge. PC=0x400 with NB_MEM_ADDR=8 -> reads mem[0] (wrap).
- With IF_FETCH_COUNT_EN: run the first scenario -> o_fetch_count=3 at halt and stays 3; it returns to 0 on reset.
